mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between instruction fetch (IFU) and load/store (LSU).
//  Serialises accesses, sequences the fixed-latency memory and returns data with a one-cycle ready pulse.
//  Raises cpu_stall so the PC and register file hold while an access is outstanding.
//  Sits between IFU/LSU and the memory storage block, in place of separate imem/dmem ports.
// PARAMETERS
//  ADDR_W      32  address width (byte address)
//  LATENCY     2   memory access cycles, mem_en held for this many cycles; legal range 1..15
//  MAX_STREAK  4   max consecutive LSU grants while IFU waits; legal range 1..15
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous reset, active high
//  if_req     in   1       fetch request, level, held until if_ready
//  if_addr    in   ADDR_W  fetch byte address
//  if_ready   out  1       one-cycle pulse: fetch done, if_rdata valid this cycle
//  if_rdata   out  32      fetched instruction word
//  ls_req     in   1       load/store request, level, held until ls_ready
//  ls_we      in   1       1 = store, 0 = load
//  ls_addr    in   ADDR_W  data byte address
//  ls_wdata   in   32      store data
//  ls_be      in   4       store byte enables
//  ls_ready   out  1       one-cycle pulse: access done, ls_rdata valid this cycle
//  ls_rdata   out  32      load data; 0 after a store
//  mem_en     out  1       memory enable
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  word-aligned address, addr[1:0] forced to 0
//  mem_wdata  out  32      write data
//  mem_be     out  4       byte enables; 4'b1111 for fetch
//  mem_rdata  in   32      read data, valid in the last cycle of ACCESS
//  cpu_stall  out  1       high while any request is pending and not being completed
// BEHAVIOUR
//  Reset (async): state=IDLE, cycle counter=0, streak=0, owner=IFU. All outputs are 0.
//   Reset mid-access aborts the access. No ready pulse is issued for it.
//  States: IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE
//   - No request: stay in IDLE.
//   - Grant LSU if ls_req && (!if_req || streak<MAX_STREAK).
//   - Otherwise grant IFU if if_req.
//   - On grant, latch owner, addr, we, wdata and be. Set cnt=LATENCY-1. Go to ACCESS.
//  ACCESS
//   - mem_en=1. mem_* are driven from the latched values. mem_we=owner_LSU&&latched_we.
//   - cnt decrements each cycle. When cnt==0, capture mem_rdata and go to DONE.
//   - ACCESS lasts exactly LATENCY cycles. Requests arriving during ACCESS are ignored until IDLE.
//  DONE
//   - mem_en=0.
//   - Owner's ready=1 for this cycle only. Its rdata shows the captured word (ls_rdata=0 if store).
//   - Unconditionally go to IDLE.
//  Latency: request seen in IDLE at cycle N -> ready at cycle N+LATENCY+1.
//   Next grant is possible at N+LATENCY+2.
//  if_rdata/ls_rdata hold their value until the next completion for the same port.
//  Streak counter
//   - Increments (saturating at 15) on each LSU grant while if_req=1.
//   - Clears on any IFU grant, and whenever if_req=0 in IDLE.
//  cpu_stall = (if_req||ls_req) && !(state==DONE). It is combinational. It is 0 in IDLE with no requests.
//  Simultaneous if_req and ls_req in IDLE with streak<MAX_STREAK: LSU wins.
//   LSU carries the older instruction.
//  Requester dropping req before ready: the access still completes and ready still pulses.
//   No new grant is made for that requester.
//  Misaligned addresses are not flagged. The low 2 address bits are dropped on mem_addr.
// TESTING
//  1. Reset held 3 cycles: all outputs 0. Release, no requests for 5 cycles: mem_en=0, cpu_stall=0.
//  2. if_req at 0x0000_0004, LATENCY=2, mem returns 0x2010_0004:
//     mem_en high 2 cycles with mem_addr=0x4, mem_be=4'hF.
//     if_ready pulses 3 cycles after the request with if_rdata=0x2010_0004.
//  3. Store: ls_we=1, addr 0x0000_0103, wdata 0xDEAD_BEEF, be 4'b0011:
//     mem_addr=0x100, mem_we=1, mem_be=4'b0011.
//     ls_ready pulses once with ls_rdata=0.
//  4. if_req and ls_req (load 0x20) both rise the same cycle:
//     LSU is granted first. ls_ready comes at N+3, if_ready at N+7. cpu_stall=1 except in the DONE cycles.
//  5. if_req held, ls_req re-asserted every cycle, MAX_STREAK=4:
//     exactly 4 LSU grants, then 1 IFU grant, then LSU again. No IFU starvation.
//  6. Assert reset during cycle 1 of ACCESS: no ready pulse, mem_en=0 immediately.
//     After release a fresh request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, fixed-latency memory between instruction fetch and load/store,
// returning data with a one-cycle ready pulse and stalling the core while an access is pending.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int LATENCY    = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  input  logic [3:0]        ls_be,
  output logic              ls_ready,
  output logic [31:0]       ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_stall
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT   = 4'(LATENCY - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          streak_q, streak_d;
  logic                owner_lsu_q, owner_lsu_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic                if_ready_q, if_ready_d;
  logic                ls_ready_q, ls_ready_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         ls_rdata_q, ls_rdata_d;
  logic                gnt_lsu_s;
  logic                gnt_ifu_s;

  // Next-state, grant decision and latched access parameters
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    owner_lsu_d = owner_lsu_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    if_ready_d  = 1'b0;
    ls_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    gnt_lsu_s   = 1'b0;
    gnt_ifu_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // LSU carries the older instruction, so it wins unless IFU has waited too long
        if (ls_req && (!if_req || (streak_q < STREAK_MAX))) begin
          gnt_lsu_s = 1'b1;
        end else if (if_req) begin
          gnt_ifu_s = 1'b1;
        end else begin
          gnt_lsu_s = 1'b0;
        end

        if (!if_req) begin
          streak_d = 4'd0;
        end else if (gnt_lsu_s) begin
          streak_d = (streak_q == 4'hF) ? 4'hF : (streak_q + 4'd1);
        end else begin
          streak_d = 4'd0;
        end

        if (gnt_lsu_s) begin
          owner_lsu_d = 1'b1;
          addr_d      = {ls_addr[ADDR_W-1:2], 2'b00};
          we_d        = ls_we;
          wdata_d     = ls_wdata;
          be_d        = ls_be;
          cnt_d       = CNT_INIT;
          mem_en_d    = 1'b1;
          mem_we_d    = ls_we;
          state_d     = ST_ACCESS;
        end else if (gnt_ifu_s) begin
          owner_lsu_d = 1'b0;
          addr_d      = {if_addr[ADDR_W-1:2], 2'b00};
          we_d        = 1'b0;
          wdata_d     = 32'd0;
          be_d        = 4'hF;
          cnt_d       = CNT_INIT;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          state_d     = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          if (owner_lsu_q) begin
            ls_ready_d = 1'b1;
            ls_rdata_d = we_q ? 32'd0 : mem_rdata;
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d    = cnt_q - 4'd1;
          mem_en_d = 1'b1;
          mem_we_d = mem_we_q;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      streak_q    <= 4'd0;
      owner_lsu_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_ready_q  <= 1'b0;
      ls_ready_q  <= 1'b0;
      if_rdata_q  <= 32'd0;
      ls_rdata_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      owner_lsu_q <= owner_lsu_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      if_ready_q  <= if_ready_d;
      ls_ready_q  <= ls_ready_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign if_ready  = if_ready_q;
  assign ls_ready  = ls_ready_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  // Released in DONE so the completing instruction can retire this cycle
  assign cpu_stall = (if_req || ls_req) && (state_q != ST_DONE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic checked against
// a transaction-level model of grants, completion times, streak fairness and memory contents.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int LAT  = 2;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, ls_req, ls_we;
  logic [AW-1:0] if_addr, ls_addr;
  logic [31:0]   ls_wdata;
  logic [3:0]    ls_be;
  logic          if_ready, ls_ready, mem_en, mem_we, cpu_stall;
  logic [31:0]   if_rdata, ls_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic          mem_init;

  logic [31:0] dev_mem [256];
  logic [31:0] ref_mem [256];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(AW), .LATENCY(LAT), .MAX_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_ready(ls_ready), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
  );

  always #5 clk = ~clk;

  // Memory device: combinational read, byte-enabled write while enabled
  assign mem_rdata = dev_mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= 32'h2010_0000 | 32'(i * 4);
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) dev_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic test_reset();
    reset = 1'b1; mem_init = 1'b1;
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h2010_0000 | 32'(i * 4);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({if_ready, ls_ready, mem_en, mem_we, cpu_stall} !== 5'b0 || if_rdata !== 32'd0 ||
          ls_rdata !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_be !== 4'd0) begin
        errors++;
        $display("FAIL reset_outputs: ctl=%b if_rdata=%h ls_rdata=%h addr=%h wdata=%h be=%h, expected all 0",
                 {if_ready, ls_ready, mem_en, mem_we, cpu_stall}, if_rdata, ls_rdata, mem_addr, mem_wdata, mem_be);
      end
    end
    reset = 1'b0; mem_init = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (mem_en !== 1'b0 || cpu_stall !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset: mem_en=%b cpu_stall=%b, expected 0 0", mem_en, cpu_stall);
      end
    end
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h0000_0004;
    #1;
    checks++;
    if (cpu_stall !== 1'b1) begin
      errors++; $display("FAIL fetch_stall_idle: got %b expected 1", cpu_stall);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k < 3) begin
        checks++;
        if ({mem_en, mem_we, if_ready} !== 3'b100 || mem_addr !== 32'h4 || mem_be !== 4'hF) begin
          errors++;
          $display("FAIL fetch_access k=%0d: en/we/rdy=%b addr=%h be=%h, expected 100 00000004 f",
                   k, {mem_en, mem_we, if_ready}, mem_addr, mem_be);
        end
      end else begin
        checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h2010_0004 || mem_en !== 1'b0 || cpu_stall !== 1'b0) begin
          errors++;
          $display("FAIL fetch_done: rdy=%b rdata=%h en=%b stall=%b, expected 1 20100004 0 0",
                   if_ready, if_rdata, mem_en, cpu_stall);
        end
        if_req = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b0 || if_rdata !== 32'h2010_0004) begin
      errors++; $display("FAIL fetch_pulse_hold: rdy=%b rdata=%h, expected 0 20100004", if_ready, if_rdata);
    end
  endtask

  task automatic test_store();
    int n;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_0103; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'b0011;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k < 3) begin
        checks++;
        if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 32'h100 || mem_be !== 4'b0011 ||
            mem_wdata !== 32'hDEAD_BEEF) begin
          errors++;
          $display("FAIL store_access k=%0d: en/we=%b addr=%h be=%b wdata=%h, expected 11 00000100 0011 deadbeef",
                   k, {mem_en, mem_we}, mem_addr, mem_be, mem_wdata);
        end
      end else begin
        checks++;
        if (ls_ready !== 1'b1 || ls_rdata !== 32'd0 || if_ready !== 1'b0 || if_rdata !== 32'h2010_0004) begin
          errors++;
          $display("FAIL store_done: ls_rdy=%b ls_rdata=%h if_rdy=%b if_rdata=%h, expected 1 0 0 20100004",
                   ls_ready, ls_rdata, if_ready, if_rdata);
        end
        ls_req = 1'b0; ls_we = 1'b0;
      end
    end
    ref_mem[64] = 32'h2010_BEEF;
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0100;
    n = 0;
    while (ls_ready !== 1'b1 && n < 10) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n != 3 || ls_rdata !== 32'h2010_BEEF) begin
      errors++; $display("FAIL store_readback: latency=%0d data=%h, expected 3 2010beef", n, ls_rdata);
    end
    ls_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; if_addr = 32'h40;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20;
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (cpu_stall !== ((k == 3 || k == 7) ? 1'b0 : 1'b1) ||
          ls_ready !== (k == 3) || if_ready !== (k == 7)) begin
        errors++;
        $display("FAIL simul_k%0d: stall=%b ls_rdy=%b if_rdy=%b, expected %b %b %b",
                 k, cpu_stall, ls_ready, if_ready, !(k == 3 || k == 7), k == 3, k == 7);
      end
      if (k == 1 || k == 5) begin
        checks++;
        if (mem_addr !== ((k == 1) ? 32'h20 : 32'h40)) begin
          errors++; $display("FAIL simul_order k%0d: addr=%h", k, mem_addr);
        end
      end
      if (k == 3) begin
        checks++;
        if (ls_rdata !== 32'h2010_0020) begin
          errors++; $display("FAIL simul_ls_data: got %h expected 20100020", ls_rdata);
        end
        ls_req = 1'b0;
      end
      if (k == 7) begin
        checks++;
        if (if_rdata !== 32'h2010_0040) begin
          errors++; $display("FAIL simul_if_data: got %h expected 20100040", if_rdata);
        end
        if_req = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_streak();
    bit seq [$];
    bit exp_seq [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int n = 0;
    if_req = 1'b1; if_addr = 32'h80;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'($urandom_range(0, 1023));
    while (seq.size() < 6 && n < 60) begin
      @(negedge clk); n++;
      if (if_ready && ls_ready) begin
        checks++; errors++; $display("FAIL streak_both_ready at cycle %0d", n);
      end
      if (ls_ready) begin
        seq.push_back(1'b1); ls_addr = 32'($urandom_range(0, 1023));
      end else if (if_ready) begin
        seq.push_back(1'b0);
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    checks++;
    if (seq.size() != 6) begin
      errors++; $display("FAIL streak_timeout: %0d completions, expected 6", seq.size());
    end
    for (int i = 0; i < seq.size(); i++) begin
      checks++;
      if (seq[i] !== exp_seq[i]) begin
        errors++; $display("FAIL streak_order[%0d]: lsu=%b expected %b", i, seq[i], exp_seq[i]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int n;
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1) begin
      errors++; $display("FAIL abort_in_access: mem_en=%b expected 1", mem_en);
    end
    reset = 1'b1; if_req = 1'b0;
    #1;
    checks++;
    if (mem_en !== 1'b0 || if_ready !== 1'b0 || mem_addr !== 32'd0 || if_rdata !== 32'd0) begin
      errors++;
      $display("FAIL abort_immediate: en=%b rdy=%b addr=%h rdata=%h, expected 0 0 0 0",
               mem_en, if_ready, mem_addr, if_rdata);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (if_ready !== 1'b0 || ls_ready !== 1'b0 || mem_en !== 1'b0) begin
        errors++; $display("FAIL abort_no_ready: if=%b ls=%b en=%b expected 0 0 0", if_ready, ls_ready, mem_en);
      end
    end
    if_req = 1'b1; if_addr = 32'h8;
    n = 0;
    while (if_ready !== 1'b1 && n < 10) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n != 3 || if_rdata !== 32'h2010_0008) begin
      errors++; $display("FAIL abort_recover: latency=%0d data=%h, expected 3 20100008", n, if_rdata);
    end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int c = 0, m_gnt = -100, m_done = -100, m_free = 0, m_streak = 0;
    bit m_lsu = 1'b0, m_we = 1'b0, if_valid = 1'b0, ls_valid = 1'b0, exp_acc, exp_rdy, drain;
    logic [31:0] m_addr = '0, m_wdata = '0, m_data = '0, m_if = '0, m_ls = '0;
    logic [3:0]  m_be = '0;
    int idx;
    for (int it = 0; it < 400; it++) begin
      @(negedge clk); c++;
      drain   = (it >= 370);
      exp_acc = (c > m_gnt) && (c <= m_gnt + LAT);
      exp_rdy = (c == m_done);
      checks++;
      if (mem_en !== exp_acc) begin
        errors++; $display("FAIL rnd_mem_en c=%0d: got %b expected %b", c, mem_en, exp_acc);
      end
      if (exp_acc) begin
        checks++;
        if (mem_addr !== m_addr || mem_we !== m_we || mem_be !== m_be || (m_we && mem_wdata !== m_wdata)) begin
          errors++;
          $display("FAIL rnd_mem_bus c=%0d: addr=%h we=%b be=%h wdata=%h, expected %h %b %h %h",
                   c, mem_addr, mem_we, mem_be, mem_wdata, m_addr, m_we, m_be, m_wdata);
        end
      end
      checks++;
      if (if_ready !== (exp_rdy && !m_lsu) || ls_ready !== (exp_rdy && m_lsu)) begin
        errors++;
        $display("FAIL rnd_ready c=%0d: if=%b ls=%b, expected %b %b", c, if_ready, ls_ready,
                 exp_rdy && !m_lsu, exp_rdy && m_lsu);
      end
      if (exp_rdy && m_lsu) begin m_ls = m_data; ls_valid = 1'b1; end
      if (exp_rdy && !m_lsu) begin m_if = m_data; if_valid = 1'b1; end
      if (if_valid) begin
        checks++;
        if (if_rdata !== m_if) begin
          errors++; $display("FAIL rnd_if_rdata c=%0d: got %h expected %h", c, if_rdata, m_if);
        end
      end
      if (ls_valid) begin
        checks++;
        if (ls_rdata !== m_ls) begin
          errors++; $display("FAIL rnd_ls_rdata c=%0d: got %h expected %h", c, ls_rdata, m_ls);
        end
      end
      if (if_req && if_ready) begin
        if_req = !drain && ($urandom % 2 == 0); if_addr = 32'($urandom_range(0, 1023));
      end else if (!if_req && !drain && ($urandom % 3 == 0)) begin
        if_req = 1'b1; if_addr = 32'($urandom_range(0, 1023));
      end
      if ((ls_req && ls_ready) || (!ls_req && !drain && ($urandom % 3 == 0))) begin
        ls_req = !drain && (ls_req ? ($urandom % 2 == 0) : 1'b1);
        ls_we = 1'($urandom); ls_addr = 32'($urandom_range(0, 1023));
        ls_wdata = $urandom; ls_be = 4'($urandom);
      end
      #1;
      checks++;
      if (cpu_stall !== ((if_req || ls_req) && !exp_rdy)) begin
        errors++; $display("FAIL rnd_stall c=%0d: got %b expected %b", c, cpu_stall, (if_req || ls_req) && !exp_rdy);
      end
      if (c >= m_free) begin
        if (!if_req) m_streak = 0;
        if (ls_req && (!if_req || m_streak < MAXS)) begin
          if (if_req) m_streak = (m_streak >= 15) ? 15 : m_streak + 1;
          m_lsu = 1'b1; m_we = ls_we; m_be = ls_be; m_wdata = ls_wdata;
          m_addr = {ls_addr[31:2], 2'b00}; idx = int'(ls_addr[9:2]);
          if (ls_we) begin
            for (int b = 0; b < 4; b++) if (ls_be[b]) ref_mem[idx][8*b +: 8] = ls_wdata[8*b +: 8];
            m_data = 32'd0;
          end else begin
            m_data = ref_mem[idx];
          end
          m_gnt = c; m_done = c + LAT + 1; m_free = c + LAT + 2;
        end else if (if_req) begin
          m_streak = 0;
          m_lsu = 1'b0; m_we = 1'b0; m_be = 4'hF;
          m_addr = {if_addr[31:2], 2'b00}; m_data = ref_mem[int'(if_addr[9:2])];
          m_gnt = c; m_done = c + LAT + 1; m_free = c + LAT + 2;
        end
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_simultaneous();
    test_streak();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
